// File: rtl/vip_bayer_bilinear_demosaic_8bit_if.sv
// Stream interface for the bilinear demosaic stage: 3x3 raw Bayer window with
// its frame/line/pixel strobes in, one interpolated RGB pixel with delayed
// strobes out.
interface vip_bayer_bilinear_demosaic_8bit_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_red;
  logic [7:0] post_img_green;
  logic [7:0] post_img_blue;

  // Window source side (the 3x3 generator / a bench)
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_red, post_img_green, post_img_blue
  );

  // Demosaic side
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_red, post_img_green, post_img_blue
  );
endinterface

// File: rtl/vip_bayer_bilinear_demosaic_8bit.sv
// Bilinear Bayer demosaic: tracks the CFA phase of the window centre and
// produces one 8-bit RGB pixel per window, two clocks after the window arrives.
// Strobes travel through the same two registers so they stay aligned.
module vip_bayer_bilinear_demosaic_8bit #(
  parameter logic [1:0] BAYER_PATTERN = 2'd0  // 0=RGGB 1=GRBG 2=GBRG 3=BGGR
) (
  input logic                             clk,
  input logic                             rst_n,
  vip_bayer_bilinear_demosaic_8bit_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int SUM2_W = DATA_W + 1;
  localparam int SUM4_W = DATA_W + 2;

  localparam logic [1:0] SITE_R  = 2'b00;
  localparam logic [1:0] SITE_GR = 2'b01;
  localparam logic [1:0] SITE_GB = 2'b10;
  localparam logic [1:0] SITE_B  = 2'b11;

  // Truncating averages; a mean of 8-bit samples never exceeds 255.
  function automatic logic [DATA_W-1:0] avg2(input logic [SUM2_W-1:0] sum);
    return sum[SUM2_W-1:1];
  endfunction

  function automatic logic [DATA_W-1:0] avg4(input logic [SUM4_W-1:0] sum);
    return sum[SUM4_W-1:2];
  endfunction

  logic       href_d, vsync_d;
  logic       col_odd, row_odd;
  logic       href_fall, vsync_rise, pix_en;
  logic [1:0] site;

  assign href_fall  = href_d & ~bus.per_frame_href;
  assign vsync_rise = bus.per_frame_vsync & ~vsync_d;
  assign pix_en     = bus.per_frame_clken & bus.per_frame_href;
  // Phase of the current pixel is the counter state before this clken updates it
  assign site       = {row_odd ^ BAYER_PATTERN[1], col_odd ^ BAYER_PATTERN[0]};

  // Phase tracking: column parity per pixel, row parity per line; vsync clear beats href toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
      col_odd <= 1'b0;
      row_odd <= 1'b0;
    end else begin
      href_d  <= bus.per_frame_href;
      vsync_d <= bus.per_frame_vsync;
      if (href_fall)
        col_odd <= 1'b0;
      else if (pix_en)
        col_odd <= ~col_odd;
      if (vsync_rise)
        row_odd <= 1'b0;
      else if (href_fall)
        row_odd <= ~row_odd;
    end
  end

  // ---- stage 1: neighbourhood sums, centre sample, site and strobes ----
  logic [SUM4_W-1:0] cross_p1, corner_p1;
  logic [SUM2_W-1:0] horiz_p1, vert_p1;
  logic [DATA_W-1:0] p22_p1;
  logic [1:0]        site_p1;
  logic              vsync_p1, href_p1, vld_p1;

  // Stage 1 registers every clock; data is simply don't-care when clken is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cross_p1  <= '0;
      corner_p1 <= '0;
      horiz_p1  <= '0;
      vert_p1   <= '0;
      p22_p1    <= '0;
      site_p1   <= SITE_R;
      vsync_p1  <= 1'b0;
      href_p1   <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      cross_p1  <= SUM4_W'(bus.matrix_p12) + SUM4_W'(bus.matrix_p21)
                 + SUM4_W'(bus.matrix_p23) + SUM4_W'(bus.matrix_p32);
      corner_p1 <= SUM4_W'(bus.matrix_p11) + SUM4_W'(bus.matrix_p13)
                 + SUM4_W'(bus.matrix_p31) + SUM4_W'(bus.matrix_p33);
      horiz_p1  <= SUM2_W'(bus.matrix_p21) + SUM2_W'(bus.matrix_p23);
      vert_p1   <= SUM2_W'(bus.matrix_p12) + SUM2_W'(bus.matrix_p32);
      p22_p1    <= bus.matrix_p22;
      site_p1   <= site;
      vsync_p1  <= bus.per_frame_vsync;
      href_p1   <= bus.per_frame_href;
      vld_p1    <= bus.per_frame_clken;
    end
  end

  // ---- stage 2: per-site channel selection into the output registers ----
  // Stage 2 picks native sample or neighbour average for each channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.post_frame_vsync <= 1'b0;
      bus.post_frame_href  <= 1'b0;
      bus.post_frame_clken <= 1'b0;
      bus.post_img_red     <= '0;
      bus.post_img_green   <= '0;
      bus.post_img_blue    <= '0;
    end else begin
      bus.post_frame_vsync <= vsync_p1;
      bus.post_frame_href  <= href_p1;
      bus.post_frame_clken <= vld_p1;
      case (site_p1)
        SITE_R: begin
          bus.post_img_red   <= p22_p1;
          bus.post_img_green <= avg4(cross_p1);
          bus.post_img_blue  <= avg4(corner_p1);
        end
        SITE_GR: begin
          bus.post_img_red   <= avg2(horiz_p1);
          bus.post_img_green <= p22_p1;
          bus.post_img_blue  <= avg2(vert_p1);
        end
        SITE_GB: begin
          bus.post_img_red   <= avg2(vert_p1);
          bus.post_img_green <= p22_p1;
          bus.post_img_blue  <= avg2(horiz_p1);
        end
        default: begin
          bus.post_img_red   <= avg4(corner_p1);
          bus.post_img_green <= avg4(cross_p1);
          bus.post_img_blue  <= p22_p1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_bayer_bilinear_demosaic_8bit.sv
// Directed bench for the bilinear demosaic: an RGGB instance and a BGGR
// instance share one stimulus stream; each cycle's expected output is
// written by hand and compared two clocks later against the selected instance.
module tb_vip_bayer_bilinear_demosaic_8bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vs, hr, ce;
  logic [7:0] w  [9];
  logic [7:0] nw [9];
  bit         sel;

  vip_bayer_bilinear_demosaic_8bit_if if0 ();
  vip_bayer_bilinear_demosaic_8bit_if if3 ();

  assign if0.per_frame_vsync = vs;
  assign if0.per_frame_href  = hr;
  assign if0.per_frame_clken = ce;
  assign if0.matrix_p11 = w[0];
  assign if0.matrix_p12 = w[1];
  assign if0.matrix_p13 = w[2];
  assign if0.matrix_p21 = w[3];
  assign if0.matrix_p22 = w[4];
  assign if0.matrix_p23 = w[5];
  assign if0.matrix_p31 = w[6];
  assign if0.matrix_p32 = w[7];
  assign if0.matrix_p33 = w[8];
  assign if3.per_frame_vsync = vs;
  assign if3.per_frame_href  = hr;
  assign if3.per_frame_clken = ce;
  assign if3.matrix_p11 = w[0];
  assign if3.matrix_p12 = w[1];
  assign if3.matrix_p13 = w[2];
  assign if3.matrix_p21 = w[3];
  assign if3.matrix_p22 = w[4];
  assign if3.matrix_p23 = w[5];
  assign if3.matrix_p31 = w[6];
  assign if3.matrix_p32 = w[7];
  assign if3.matrix_p33 = w[8];

  vip_bayer_bilinear_demosaic_8bit #(.BAYER_PATTERN(2'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  vip_bayer_bilinear_demosaic_8bit #(.BAYER_PATTERN(2'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic       o_vs, o_hr, o_ce;
  logic [7:0] o_r, o_g, o_b;
  always_comb begin
    o_vs = sel ? if3.post_frame_vsync : if0.post_frame_vsync;
    o_hr = sel ? if3.post_frame_href  : if0.post_frame_href;
    o_ce = sel ? if3.post_frame_clken : if0.post_frame_clken;
    o_r  = sel ? if3.post_img_red     : if0.post_img_red;
    o_g  = sel ? if3.post_img_green   : if0.post_img_green;
    o_b  = sel ? if3.post_img_blue    : if0.post_img_blue;
  end

  typedef struct packed {
    logic       vs, hr, ce, chk;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t e1, e2;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic win(input logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33);
    nw[0] = a11; nw[1] = a12; nw[2] = a13;
    nw[3] = a21; nw[4] = a22; nw[5] = a23;
    nw[6] = a31; nw[7] = a32; nw[8] = a33;
  endtask

  // One clock: check the output due from two cycles ago, then drive the next input.
  task automatic cyc(input logic v, h, c, k, input logic [7:0] r, g, b);
    @(negedge clk);
    check_val("vsync", 8'(o_vs), 8'(e2.vs));
    check_val("href",  8'(o_hr), 8'(e2.hr));
    check_val("clken", 8'(o_ce), 8'(e2.ce));
    if (e2.chk) begin
      check_val("red",   o_r, e2.r);
      check_val("green", o_g, e2.g);
      check_val("blue",  o_b, e2.b);
    end
    e2 = e1;
    e1 = '{vs: v, hr: h, ce: c, chk: k, r: r, g: g, b: b};
    vs = v; hr = h; ce = c;
    for (int i = 0; i < 9; i++) w[i] = nw[i];
  endtask

  task automatic blank();
    win(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic vpulse();
    win(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Sweep window: corners 40, vertical neighbours 100, horizontal 60, centre 200.
  // 0=R site, 1=G on R row, 2=G on B row, 3=B site
  task automatic px(input int s);
    win(40, 100, 40, 60, 200, 60, 40, 100, 40);
    case (s)
      0:       cyc(0, 1, 1, 1, 200,  80,  40);
      1:       cyc(0, 1, 1, 1,  60, 200, 100);
      2:       cyc(0, 1, 1, 1, 100, 200,  60);
      default: cyc(0, 1, 1, 1,  40,  80, 200);
    endcase
  endtask

  task automatic line4(input int a, b);
    px(a); px(b); px(a); px(b);
    blank();
  endtask

  task automatic zero_pipe();
    e1 = '{vs: 0, hr: 0, ce: 0, chk: 1, r: 0, g: 0, b: 0};
    e2 = e1;
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    vs = 0; hr = 0; ce = 0;
    for (int i = 0; i < 9; i++) begin w[i] = '0; nw[i] = '0; end
    zero_pipe();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vsync0", 8'(if0.post_frame_vsync), 0);
    check_val("rst_href0",  8'(if0.post_frame_href), 0);
    check_val("rst_clken0", 8'(if0.post_frame_clken), 0);
    check_val("rst_red0",   if0.post_img_red, 0);
    check_val("rst_green0", if0.post_img_green, 0);
    check_val("rst_blue0",  if0.post_img_blue, 0);
    check_val("rst_red3",   if3.post_img_red, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat field 4x4, RGGB
    vpulse();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        win(100, 100, 100, 100, 100, 100, 100, 100, 100);
        cyc(0, 1, 1, 1, 100, 100, 100);
      end
      blank();
    end
    blank();

    // RGGB directed windows at the start of a frame
    vpulse();
    win(40, 80, 40, 80, 200, 80, 40, 80, 40);
    cyc(0, 1, 1, 1, 200, 80, 40);
    win(0, 50, 0, 10, 90, 30, 0, 70, 0);
    cyc(0, 1, 1, 1, 20, 90, 60);
    win(3, 1, 3, 1, 7, 1, 3, 2, 3);
    cyc(0, 1, 1, 1, 7, 1, 3);
    px(1);
    blank();
    line4(2, 3);

    // Reset asserted mid-line while valid data is on the outputs
    px(0); px(1); px(0);
    #2 rst_n = 1'b0;
    vs = 0; hr = 0; ce = 0;
    for (int i = 0; i < 9; i++) begin w[i] = '0; nw[i] = '0; end
    #1;
    check_val("midrst_vsync", 8'(if0.post_frame_vsync), 0);
    check_val("midrst_href",  8'(if0.post_frame_href), 0);
    check_val("midrst_clken", 8'(if0.post_frame_clken), 0);
    check_val("midrst_red",   if0.post_img_red, 0);
    check_val("midrst_green", if0.post_img_green, 0);
    check_val("midrst_blue",  if0.post_img_blue, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    zero_pipe();
    win(40, 80, 40, 80, 200, 80, 40, 80, 40);
    cyc(0, 1, 1, 1, 200, 80, 40);
    px(1);
    blank();
    blank();

    // BGGR phase sweep
    sel = 1'b1;
    vpulse();
    line4(3, 2);
    line4(1, 0);
    px(3); px(2);
    win(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    px(3); px(2);
    blank();
    line4(1, 0);

    // Second frame of three lines; its last href fall coincides with vsync rise
    vpulse();
    line4(3, 2);
    line4(1, 0);
    px(3); px(2); px(3); px(2);
    vpulse();
    blank();
    line4(3, 2);
    blank();
    blank();
    blank();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
